acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 35, SHALL set the SPI words per acquisition frame (32 amplifier + 3 aux); legal range 2..63.
REQ-002 Parameter ACK_TIMEOUT, default 1023, SHALL set the maximum cycles spi_req may stay high without spi_ack before a timeout error.
REQ-003 pl_clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 pl_rstn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 control_reg_pl  input  32  SHALL carry control, already synchronized to pl_clk: [0] run, [1] clear_count, [31:16] frame_limit (0 = continuous).
REQ-006 spi_req  output  1  SHALL request one SPI word transfer.
REQ-007 spi_ack  input  1  SHALL complete the transfer in any cycle where spi_req and spi_ack are both high.
REQ-008 spi_word_idx  output  6  SHALL give the index of the requested word, 0..WORDS_PER_FRAME-1.
REQ-009 frame_start  output  1  SHALL pulse for one cycle at each frame start.
REQ-010 status_reg_pl  output  32  SHALL report [0] busy, [1] done, [2] timeout_err, [3] run, [6:4] state code, [7] 0, [31:8] frame_count.

Function
REQ-011 FSM states SHALL be IDLE(0), RUN(1), GAP(2), DONE(3), ERROR(4); the state code appears in status[6:4].
REQ-012 IDLE: a run rising edge (run=1 while the previous-cycle run was 0) SHALL enter RUN with spi_word_idx=0; spi_req and frame_start SHALL be high on the next cycle.
REQ-013 RUN: spi_req SHALL be high and spi_word_idx stable until handshake; on handshake, idx < WORDS_PER_FRAME-1 increments idx; idx = WORDS_PER_FRAME-1 sets idx to 0, increments frame_count, and enters GAP.
REQ-014 GAP (spi_req low, exactly 1 cycle): run=0 enters IDLE; frame_limit≠0 and frame_count==frame_limit (zero-extended) enters DONE; otherwise enters RUN with a frame_start pulse.
REQ-015 Deasserting run mid-frame SHALL NOT abort the frame; stop occurs only at GAP.
REQ-016 DONE SHALL hold done=1 and spi_req=0 until run=0, then enter IDLE; a run still high SHALL NOT restart.
REQ-017 A watchdog SHALL count cycles of spi_req=1 without spi_ack and clear on each handshake; at count ACK_TIMEOUT the FSM enters ERROR, drops spi_req, and sets timeout_err.
REQ-018 ERROR SHALL hold until run=0, then enter IDLE; timeout_err stays sticky until the next run rising edge.
REQ-019 frame_count SHALL be 24 bits and wrap from 0xFFFFFF to 0.
REQ-020 clear_count=1 SHALL zero frame_count only in IDLE; it is ignored in other states.
REQ-021 If clear_count and a run rising edge occur in the same IDLE cycle, the count SHALL clear and the start SHALL proceed.
REQ-022 busy SHALL be 1 in RUN and GAP; done SHALL be 1 only in DONE; status[3] SHALL mirror control_reg_pl[0].
REQ-023 All outputs SHALL be registered; status SHALL reflect the state with 1-cycle latency.

Reset
REQ-024 With pl_rstn=0 at a clock edge: state=IDLE, spi_req=0, spi_word_idx=0, frame_start=0, frame_count=0, watchdog=0, timeout_err=0, run-edge history=0, status_reg_pl=0.
REQ-025 Reset mid-frame SHALL drop spi_req on the following edge without completing the frame.
REQ-026 run held high through reset release SHALL NOT start acquisition until it is deasserted and reasserted.

Structure
REQ-027 Package acq_seq_pkg SHALL hold the state enum/codes, control bit positions (RUN_BIT, CLR_BIT, LIMIT_LSB/MSB) and status bit positions, shared with software header generation.
REQ-028 The watchdog SHALL be sub-module acq_ack_watchdog (inputs clk, rstn, arm, kick; output expired).

Verification
REQ-029 WORDS_PER_FRAME=35, limit=2, ack every cycle: run 0->1 gives 70 handshakes with idx 0..34 twice, 2 frame_start pulses, then DONE, status=0x0000_023A.
REQ-030 limit=0, run dropped at word 10 of frame 3: words 11..34 still complete, then IDLE with frame_count=3.
REQ-031 ACK_TIMEOUT=16, spi_ack held low: spi_req drops 16 cycles after rising, state=ERROR, status[2]=1; run low -> IDLE with status[2] still 1; the next run rise clears it.
REQ-032 frame_count preloaded near 0xFFFFFF (via continuous run): the next frame wraps it to 0x000000.
REQ-033 clear_count asserted during RUN does not change frame_count; clear_count with a run rise in IDLE gives count 0 and a start.
REQ-034 pl_rstn low at word 20 of a frame: spi_req=0 and status=0 next cycle; run held high after release gives no restart.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Shared constants for the acquisition sequencer: FSM codes, control/status
// register bit positions and the packed status layout used by software headers.
package acq_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam int RUN_BIT   = 0;
    localparam int CLR_BIT   = 1;
    localparam int LIMIT_LSB = 16;
    localparam int LIMIT_MSB = 31;

    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_TOERR_BIT  = 2;
    localparam int STAT_RUN_BIT    = 3;
    localparam int STAT_STATE_LSB  = 4;
    localparam int STAT_STATE_MSB  = 6;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_MSB  = 31;

    localparam int FRAME_COUNT_W = 24;

    // Field order matches the STAT_* positions above, MSB first.
    typedef struct packed {
        logic [FRAME_COUNT_W-1:0] frame_count;
        logic                     rsvd;
        logic [2:0]               state;
        logic                     run;
        logic                     timeout_err;
        logic                     done;
        logic                     busy;
    } status_t;

endpackage

// File: rtl/acq_ack_watchdog.sv
// Counts consecutive armed cycles without a kick; expired fires on the cycle
// the count would reach TIMEOUT so the owner can act on that same edge.
module acq_ack_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rstn,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (arm && !kick) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign expired = arm && !kick && (cnt == LAST);

endmodule

// File: rtl/acq_sequencer.sv
// Frame sequencer: issues WORDS_PER_FRAME SPI word requests per frame, counts
// frames, honours a frame limit and aborts to ERROR when the SPI side stalls.
module acq_sequencer #(
    parameter int WORDS_PER_FRAME = 35,
    parameter int ACK_TIMEOUT     = 1023
) (
    input  logic        pl_clk,
    input  logic        pl_rstn,
    input  logic [31:0] control_reg_pl,
    output logic        spi_req,
    input  logic        spi_ack,
    output logic [5:0]  spi_word_idx,
    output logic        frame_start,
    output logic [31:0] status_reg_pl
);

    import acq_seq_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(WORDS_PER_FRAME - 1);

    logic                     run;
    logic                     clr;
    logic [15:0]              limit;
    logic                     unused_ctrl;
    logic [2:0]               state;
    logic                     run_q;
    logic                     run_armed;
    logic [FRAME_COUNT_W-1:0] frame_count;
    logic                     timeout_err;
    logic                     wd_expired;
    logic                     handshake;
    logic                     run_rise;
    logic                     limit_hit;
    status_t                  status_next;

    assign run         = control_reg_pl[RUN_BIT];
    assign clr         = control_reg_pl[CLR_BIT];
    assign limit       = control_reg_pl[LIMIT_MSB:LIMIT_LSB];
    assign unused_ctrl = ^control_reg_pl[LIMIT_LSB-1:CLR_BIT+1];

    // run_armed stays low until run has been seen low after reset, so a run
    // bit held across reset release cannot masquerade as a rising edge.
    assign run_rise  = run && !run_q && run_armed;
    assign handshake = spi_req && spi_ack;
    assign limit_hit = (limit != 16'd0) && (frame_count == {8'd0, limit});

    acq_ack_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk     (pl_clk),
        .rstn    (pl_rstn),
        .arm     (spi_req),
        .kick    (spi_ack),
        .expired (wd_expired)
    );

    always_comb begin
        status_next             = '0;
        status_next.frame_count = frame_count;
        status_next.state       = state;
        status_next.run         = run;
        status_next.timeout_err = timeout_err;
        status_next.done        = (state == ST_DONE);
        status_next.busy        = (state == ST_RUN) || (state == ST_GAP);
    end

    always_ff @(posedge pl_clk) begin
        if (!pl_rstn) begin
            state         <= ST_IDLE;
            spi_req       <= 1'b0;
            spi_word_idx  <= '0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
            timeout_err   <= 1'b0;
            run_q         <= 1'b0;
            run_armed     <= 1'b0;
            status_reg_pl <= '0;
        end else begin
            run_q         <= run;
            run_armed     <= run_armed || !run;
            frame_start   <= 1'b0;
            status_reg_pl <= status_next;

            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        frame_count <= '0;
                    end
                    if (run_rise) begin
                        state        <= ST_RUN;
                        spi_req      <= 1'b1;
                        frame_start  <= 1'b1;
                        spi_word_idx <= '0;
                        timeout_err  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (wd_expired) begin
                        state       <= ST_ERROR;
                        spi_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (handshake) begin
                        if (spi_word_idx == LAST_IDX) begin
                            spi_word_idx <= '0;
                            frame_count  <= frame_count + 1'b1;
                            spi_req      <= 1'b0;
                            state        <= ST_GAP;
                        end else begin
                            spi_word_idx <= spi_word_idx + 6'd1;
                        end
                    end
                end
                // Frame boundary: the only place a stop or limit takes effect.
                ST_GAP: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (limit_hit) begin
                        state <= ST_DONE;
                    end else begin
                        state       <= ST_RUN;
                        spi_req     <= 1'b1;
                        frame_start <= 1'b1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    spi_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: frame limit, mid-frame stop, ack timeout,
// count clear/wrap and reset behaviour, each checked against hand-derived values.
module tb_acq_sequencer;

    logic        pl_clk = 1'b0;
    logic        pl_rstn = 1'b0;
    logic [31:0] control_reg_pl = '0;
    logic        spi_ack = 1'b0;
    logic        spi_req;
    logic [5:0]  spi_word_idx;
    logic        frame_start;
    logic [31:0] status_reg_pl;

    int tests_run = 0;
    int tests_failed = 0;

    acq_sequencer #(
        .WORDS_PER_FRAME (35),
        .ACK_TIMEOUT     (16)
    ) dut (
        .pl_clk         (pl_clk),
        .pl_rstn        (pl_rstn),
        .control_reg_pl (control_reg_pl),
        .spi_req        (spi_req),
        .spi_ack        (spi_ack),
        .spi_word_idx   (spi_word_idx),
        .frame_start    (frame_start),
        .status_reg_pl  (status_reg_pl)
    );

    always #5 pl_clk = ~pl_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    function automatic logic [31:0] ctrl(input logic [15:0] limit, input logic clr, input logic run);
        return {limit, 14'd0, clr, run};
    endfunction

    task automatic test_reset();
        pl_rstn = 1'b0;
        control_reg_pl = '0;
        spi_ack = 1'b0;
        repeat (3) @(negedge pl_clk);
        tests_run++;
        if (spi_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b, required 0", spi_req); end
        tests_run++;
        if (spi_word_idx !== 6'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d, required 0", spi_word_idx); end
        tests_run++;
        if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
        tests_run++;
        if (status_reg_pl !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h, required 00000000", status_reg_pl); end
        pl_rstn = 1'b1;
        repeat (2) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl !== 32'h0) begin tests_failed++; $display("FAIL idle_status: got %h, required 00000000", status_reg_pl); end
    endtask

    task automatic test_limit_frames();
        int hs = 0;
        int fs = 0;
        int idx_err = 0;
        int cyc = 0;
        logic [5:0] exp_idx = 6'd0;
        bit reached = 1'b0;
        spi_ack = 1'b1;
        control_reg_pl = ctrl(16'd2, 1'b0, 1'b0);
        @(negedge pl_clk);
        control_reg_pl = ctrl(16'd2, 1'b0, 1'b1);
        @(negedge pl_clk);
        tests_run++;
        if ({spi_req, frame_start, spi_word_idx} !== {1'b1, 1'b1, 6'd0}) begin
            tests_failed++;
            $display("FAIL start_cycle: got req=%b fs=%b idx=%0d, required req=1 fs=1 idx=0", spi_req, frame_start, spi_word_idx);
        end
        while (!reached && cyc < 400) begin
            if (frame_start) fs++;
            if (spi_req && spi_ack) begin
                if (spi_word_idx !== exp_idx) idx_err++;
                exp_idx = (exp_idx == 6'd34) ? 6'd0 : exp_idx + 6'd1;
                hs++;
            end
            if (status_reg_pl[6:4] == 3'd3) reached = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if (reached !== 1'b1) begin tests_failed++; $display("FAIL limit_done_reached: got %b, required 1 within 400 cycles", reached); end
        tests_run++;
        if (hs !== 70) begin tests_failed++; $display("FAIL limit_handshakes: got %0d, required 70", hs); end
        tests_run++;
        if (fs !== 2) begin tests_failed++; $display("FAIL limit_frame_starts: got %0d, required 2", fs); end
        tests_run++;
        if (idx_err !== 0) begin tests_failed++; $display("FAIL limit_idx_seq: got %0d bad indices, required 0", idx_err); end
        tests_run++;
        if (status_reg_pl !== 32'h0000023A) begin tests_failed++; $display("FAIL limit_status: got %h, required 0000023a", status_reg_pl); end
        repeat (4) @(negedge pl_clk);
        tests_run++;
        if ({spi_req, status_reg_pl} !== {1'b0, 32'h0000023A}) begin
            tests_failed++;
            $display("FAIL done_hold: got req=%b status=%h, required req=0 status=0000023a", spi_req, status_reg_pl);
        end
        control_reg_pl = ctrl(16'd2, 1'b0, 1'b0);
        repeat (3) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl !== 32'h00000200) begin tests_failed++; $display("FAIL done_to_idle: got %h, required 00000200", status_reg_pl); end
    endtask

    task automatic test_run_stop();
        int fs = 0;
        int post = 0;
        int idx_err = 0;
        int cyc = 0;
        logic [5:0] exp_idx = 6'd0;
        logic [23:0] mid_count = 24'hFFFFFF;
        bit dropped = 1'b0;
        bit idle = 1'b0;
        spi_ack = 1'b1;
        // clear held high with the run rise and throughout the run
        control_reg_pl = ctrl(16'd0, 1'b1, 1'b1);
        @(negedge pl_clk);
        tests_run++;
        if ({spi_req, frame_start} !== 2'b11) begin tests_failed++; $display("FAIL clr_start: got req=%b fs=%b, required 1 1", spi_req, frame_start); end
        while (!idle && cyc < 300) begin
            if (frame_start) fs++;
            if (spi_req && spi_ack) begin
                if (spi_word_idx !== exp_idx) idx_err++;
                if (dropped) post++;
                else if (fs == 3 && spi_word_idx == 6'd10) begin
                    mid_count = status_reg_pl[31:8];
                    control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
                    dropped = 1'b1;
                end
                exp_idx = (exp_idx == 6'd34) ? 6'd0 : exp_idx + 6'd1;
            end
            if (dropped && status_reg_pl[6:4] == 3'd0) idle = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if (idle !== 1'b1) begin tests_failed++; $display("FAIL stop_idle_reached: got %b, required 1 within 300 cycles", idle); end
        tests_run++;
        if (mid_count !== 24'd2) begin tests_failed++; $display("FAIL clr_in_run: got count %0d, required 2", mid_count); end
        tests_run++;
        if (post !== 24) begin tests_failed++; $display("FAIL stop_tail_words: got %0d, required 24", post); end
        tests_run++;
        if ({fs, idx_err} !== {32'd3, 32'd0}) begin tests_failed++; $display("FAIL stop_frames: got fs=%0d idx_err=%0d, required 3 0", fs, idx_err); end
        tests_run++;
        if (status_reg_pl !== 32'h00000300) begin tests_failed++; $display("FAIL stop_status: got %h, required 00000300", status_reg_pl); end
    endtask

    task automatic test_timeout();
        int high = 0;
        int cyc = 0;
        bit idle = 1'b0;
        spi_ack = 1'b0;
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b1);
        @(negedge pl_clk);
        while (spi_req && cyc < 100) begin
            high++;
            @(negedge pl_clk);
            cyc++;
        end
        tests_run++;
        if (high !== 16) begin tests_failed++; $display("FAIL timeout_req_cycles: got %0d, required 16", high); end
        @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl !== 32'h0000034C) begin tests_failed++; $display("FAIL timeout_status: got %h, required 0000034c", status_reg_pl); end
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
        repeat (3) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl[7:0] !== 8'h04) begin tests_failed++; $display("FAIL timeout_sticky: got %h, required 04", status_reg_pl[7:0]); end
        spi_ack = 1'b1;
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b1);
        repeat (2) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl[2:0] !== 3'b001) begin tests_failed++; $display("FAIL timeout_cleared: got %b, required 001", status_reg_pl[2:0]); end
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
        cyc = 0;
        while (!idle && cyc < 100) begin
            if (status_reg_pl[6:4] == 3'd0) idle = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if ({idle, status_reg_pl} !== {1'b1, 32'h00000400}) begin
            tests_failed++;
            $display("FAIL timeout_recover: got idle=%b status=%h, required 1 00000400", idle, status_reg_pl);
        end
    endtask

    task automatic test_clear_idle();
        control_reg_pl = ctrl(16'd0, 1'b1, 1'b0);
        repeat (2) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl !== 32'h0) begin tests_failed++; $display("FAIL clear_idle: got %h, required 00000000", status_reg_pl); end
        control_reg_pl = '0;
    endtask

    task automatic test_wrap();
        int cyc = 0;
        bit idle = 1'b0;
        force dut.frame_count = 24'hFFFFFF;
        @(negedge pl_clk);
        release dut.frame_count;
        repeat (2) @(negedge pl_clk);
        tests_run++;
        if (status_reg_pl !== 32'hFFFFFF00) begin tests_failed++; $display("FAIL wrap_preload: got %h, required ffffff00", status_reg_pl); end
        spi_ack = 1'b1;
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b1);
        @(negedge pl_clk);
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
        repeat (3) @(negedge pl_clk);
        while (!idle && cyc < 100) begin
            if (status_reg_pl[6:4] == 3'd0) idle = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if ({idle, status_reg_pl} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap_count: got idle=%b status=%h, required 1 00000000", idle, status_reg_pl);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc = 0;
        bit hit = 1'b0;
        bit restart = 1'b0;
        bit idle = 1'b0;
        spi_ack = 1'b1;
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b1);
        @(negedge pl_clk);
        while (!hit && cyc < 100) begin
            if (spi_req && spi_word_idx == 6'd20) hit = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("FAIL rst_word20_reached: got %b, required 1", hit); end
        pl_rstn = 1'b0;
        @(negedge pl_clk);
        tests_run++;
        if ({spi_req, frame_start, spi_word_idx, status_reg_pl} !== {1'b0, 1'b0, 6'd0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_mid_frame: got req=%b fs=%b idx=%0d status=%h, required 0 0 0 00000000",
                     spi_req, frame_start, spi_word_idx, status_reg_pl);
        end
        pl_rstn = 1'b1;
        repeat (10) begin
            @(negedge pl_clk);
            if (spi_req || status_reg_pl[6:4] != 3'd0) restart = 1'b1;
        end
        tests_run++;
        if ({restart, status_reg_pl[3]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_no_restart: got restart=%b run=%b, required 0 1", restart, status_reg_pl[3]);
        end
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
        repeat (2) @(negedge pl_clk);
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b1);
        @(negedge pl_clk);
        tests_run++;
        if ({spi_req, frame_start} !== 2'b11) begin tests_failed++; $display("FAIL rst_rearm_start: got req=%b fs=%b, required 1 1", spi_req, frame_start); end
        control_reg_pl = ctrl(16'd0, 1'b0, 1'b0);
        cyc = 0;
        repeat (2) @(negedge pl_clk);
        while (!idle && cyc < 100) begin
            if (status_reg_pl[6:4] == 3'd0) idle = 1'b1;
            else begin
                @(negedge pl_clk);
                cyc++;
            end
        end
        tests_run++;
        if ({idle, status_reg_pl} !== {1'b1, 32'h00000100}) begin
            tests_failed++;
            $display("FAIL rst_rearm_frame: got idle=%b status=%h, required 1 00000100", idle, status_reg_pl);
        end
    endtask

    initial begin
        test_reset();
        test_limit_frames();
        test_run_stop();
        test_timeout();
        test_clear_idle();
        test_wrap();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
